// File: rtl/tft_spi_feeder.sv
// rtl/tft_spi_feeder.sv - byte FIFO feeding an Avalon-style SPI core for a TFT panel, with D/C pin sequencing
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in_valid/in_ready       host byte handshake; in_data byte, in_dc its D/C tag
//   spi_select, spi_write_n, spi_read_n, spi_addr, spi_wdata   SPI core register port
//   spi_rdata               SPI core read data (status bit 5 = TMT)
//   spi_readyfordata        SPI core TRDY
//   spi_dataavailable       SPI core RRDY
//   tft_dc                  TFT D/C pin
//   busy, fifo_level        activity flag and FIFO occupancy
module tft_spi_feeder #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [7:0]                    in_data,
    input  logic                          in_dc,
    output logic                          spi_select,
    output logic                          spi_write_n,
    output logic                          spi_read_n,
    output logic [2:0]                    spi_addr,
    output logic [15:0]                   spi_wdata,
    input  logic [15:0]                   spi_rdata,
    input  logic                          spi_readyfordata,
    input  logic                          spi_dataavailable,
    output logic                          tft_dc,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     FULL_LVL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [3:0] {
        S_IDLE, S_RD1, S_RD2, S_ST1, S_ST2, S_DCSET, S_WR1, S_WR2, S_GAP
    } state_e;

    state_e          state_q;
    logic [8:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [AW:0]     level_q, level_d;
    logic            sel_q, wr_n_q, rd_n_q, tft_dc_q;
    logic [2:0]      addr_q;
    logic [15:0]     wdata_q;

    logic [8:0]      head;
    logic            fifo_nempty, push, pop;

    // Only the TMT status bit is consumed; received data is discarded.
    logic            unused_rdata;
    assign unused_rdata = ^{spi_rdata[15:6], spi_rdata[4:0]};

    assign head        = mem_q[rptr_q];
    assign fifo_nempty = (level_q != '0);
    assign in_ready    = (level_q != FULL_LVL);
    assign push        = in_valid && in_ready;
    // Pop coincides with the IDLE->WR1 decision so the head is consumed exactly once.
    assign pop         = (state_q == S_IDLE) && !spi_dataavailable && fifo_nempty &&
                         (head[8] == tft_dc_q) && spi_readyfordata;

    always_comb begin
        level_d = level_q;
        if (push && !pop)
            level_d = level_q + (AW + 1)'(1);
        else if (pop && !push)
            level_d = level_q - (AW + 1)'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wptr_q] <= {in_dc, in_data};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push)
                wptr_q <= wptr_q + AW'(1);
            if (pop)
                rptr_q <= rptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    // Register-port outputs are registered: they are set on the edge entering the
    // first access cycle and cleared on the edge leaving the second.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            sel_q    <= 1'b0;
            wr_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            addr_q   <= 3'd0;
            wdata_q  <= 16'h0000;
            tft_dc_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (spi_dataavailable) begin
                        state_q <= S_RD1;
                        sel_q   <= 1'b1;
                        rd_n_q  <= 1'b0;
                        addr_q  <= 3'd0;
                    end else if (fifo_nempty && (head[8] != tft_dc_q)) begin
                        state_q <= S_ST1;
                        sel_q   <= 1'b1;
                        rd_n_q  <= 1'b0;
                        addr_q  <= 3'd2;
                    end else if (pop) begin
                        state_q <= S_WR1;
                        sel_q   <= 1'b1;
                        wr_n_q  <= 1'b0;
                        addr_q  <= 3'd1;
                        wdata_q <= {8'h00, head[7:0]};
                    end
                end
                S_RD1: state_q <= S_RD2;
                S_ST1: state_q <= S_ST2;
                S_WR1: state_q <= S_WR2;
                S_RD2, S_WR2: begin
                    state_q <= S_GAP;
                    sel_q   <= 1'b0;
                    wr_n_q  <= 1'b1;
                    rd_n_q  <= 1'b1;
                    addr_q  <= 3'd0;
                    wdata_q <= 16'h0000;
                end
                S_ST2: begin
                    // D/C may only flip once the shifter has fully drained (TMT).
                    state_q <= spi_rdata[5] ? S_DCSET : S_GAP;
                    sel_q   <= 1'b0;
                    rd_n_q  <= 1'b1;
                    addr_q  <= 3'd0;
                end
                S_DCSET: begin
                    tft_dc_q <= head[8];
                    state_q  <= S_IDLE;
                end
                S_GAP:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign spi_select  = sel_q;
    assign spi_write_n = wr_n_q;
    assign spi_read_n  = rd_n_q;
    assign spi_addr    = addr_q;
    assign spi_wdata   = wdata_q;
    assign tft_dc      = tft_dc_q;
    assign busy        = fifo_nempty || (state_q != S_IDLE);
    assign fifo_level  = level_q;

endmodule

// File: tb/tb_tft_spi_feeder.sv
// tb/tb_tft_spi_feeder.sv - scoreboard bench for tft_spi_feeder
module tb_tft_spi_feeder;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_dc = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        spi_select, spi_write_n, spi_read_n;
    logic [2:0]  spi_addr;
    logic [15:0] spi_wdata;
    logic [15:0] spi_rdata;
    logic        spi_readyfordata;
    logic        spi_dataavailable;
    logic        tft_dc, busy;
    logic [4:0]  fifo_level;

    logic        trdy = 1'b0;
    int          rx_req = 0;
    int          rx_done = 0;
    int          polls = 0;
    int          tmt_after = 0;

    assign spi_readyfordata  = trdy;
    assign spi_dataavailable = (rx_req != rx_done);
    assign spi_rdata         = (polls > tmt_after) ? 16'h0020 : 16'h0000;

    tft_spi_feeder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .in_dc             (in_dc),
        .spi_select        (spi_select),
        .spi_write_n       (spi_write_n),
        .spi_read_n        (spi_read_n),
        .spi_addr          (spi_addr),
        .spi_wdata         (spi_wdata),
        .spi_rdata         (spi_rdata),
        .spi_readyfordata  (spi_readyfordata),
        .spi_dataavailable (spi_dataavailable),
        .tft_dc            (tft_dc),
        .busy              (busy),
        .fifo_level        (fifo_level)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err = 0;
    logic [8:0]  exp_q[$];
    int          log_q[$];
    int          cyc = 0;
    int          sel_len = 0;
    logic        prev_sel = 1'b0;
    logic        prev_trdy = 1'b0;
    int          last_wr = -100;
    logic [8:0]  sb_e;
    logic [15:0] wd_first = 16'h0000;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    // Access codes: 1 = write, 2 = rx read, 3 = status poll.
    function automatic logic [31:0] enc(input string s);
        logic [31:0] c = 32'd0;
        for (int i = 0; i < s.len(); i++)
            c = (c << 2) | ((s[i] == "W") ? 32'd1 : (s[i] == "R") ? 32'd2 : 32'd3);
        return c;
    endfunction

    function automatic logic [31:0] log_code(input int base);
        logic [31:0] c = 32'd0;
        for (int i = base; i < log_q.size(); i++)
            c = (c << 2) | 32'(log_q[i]);
        return c;
    endfunction

    // Bus monitor and SPI core model, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            sel_len  = 0;
            prev_sel = 1'b0;
            last_wr  = -100;
        end else begin
            if (spi_select) begin
                sel_len++;
                check_eq("one_strobe", 32'(spi_write_n ^ spi_read_n), 32'd1);
                if (!prev_sel) begin
                    if (!spi_write_n) begin
                        log_q.push_back(1);
                        wd_first = spi_wdata;
                        check_eq("wr_addr", 32'(spi_addr), 32'd1);
                        check_eq("trdy_at_issue", 32'(prev_trdy), 32'd1);
                        check_eq("wr_spacing_ge3", 32'((cyc - last_wr) >= 3), 32'd1);
                        last_wr = cyc;
                        check_eq("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
                        if (exp_q.size() != 0) begin
                            sb_e = exp_q.pop_front();
                            check_eq("wdata", 32'(spi_wdata), 32'({8'h00, sb_e[7:0]}));
                            check_eq("tft_dc_at_write", 32'(tft_dc), 32'(sb_e[8]));
                        end
                    end else if (spi_addr == 3'd0) begin
                        log_q.push_back(2);
                        rx_done++;
                    end else begin
                        check_eq("poll_addr", 32'(spi_addr), 32'd2);
                        log_q.push_back(3);
                        polls++;
                    end
                end else if (!spi_write_n) begin
                    check_eq("wdata_hold", 32'(spi_wdata), 32'(wd_first));
                end
            end else begin
                if (prev_sel)
                    check_eq("access_len", 32'(sel_len), 32'd2);
                sel_len = 0;
                check_eq("idle_outputs", 32'({spi_write_n, spi_read_n, spi_addr, spi_wdata}),
                         32'({1'b1, 1'b1, 3'd0, 16'h0000}));
            end
            prev_sel = spi_select;
        end
        prev_trdy = trdy;
    end

    // Called at posedge+1; offers one byte for one edge.
    task automatic push_try(input logic dc, input logic [7:0] d, output logic acc);
        in_valid = 1'b1;
        in_dc    = dc;
        in_data  = d;
        @(negedge clk);
        acc = in_ready;
        if (acc)
            exp_q.push_back({dc, d});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   base;
        int   nacc;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_level", 32'(fifo_level), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_tft_dc", 32'(tft_dc), 32'd0);
        check_eq("rst_spi", 32'({spi_select, spi_write_n, spi_read_n, spi_addr, spi_wdata}),
                 32'({1'b0, 1'b1, 1'b1, 3'd0, 16'h0000}));
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Three command bytes, no D/C change.
        trdy = 1'b1;
        base = log_q.size();
        push_try(1'b0, 8'h2A, acc);
        push_try(1'b0, 8'h00, acc);
        push_try(1'b0, 8'h10, acc);
        wait_done("cmd3");
        check_eq("cmd3_log", log_code(base), enc("WWW"));
        check_eq("cmd3_tft_dc", 32'(tft_dc), 32'd0);

        // Command then data: two polls see TMT=0, third sees TMT=1.
        base = log_q.size();
        tmt_after = polls + 2;
        push_try(1'b0, 8'h2C, acc);
        push_try(1'b1, 8'hFF, acc);
        wait_done("dcsw");
        check_eq("dcsw_log", log_code(base), enc("WSSSW"));
        check_eq("dcsw_tft_dc", 32'(tft_dc), 32'd1);

        // Back-pressure: TRDY low, 20 offers, only DEPTH accepted.
        trdy = 1'b0;
        base = log_q.size();
        nacc = 0;
        for (int i = 0; i < 20; i++) begin
            push_try(1'b1, 8'h40 + 8'(i), acc);
            if (acc) nacc++;
        end
        repeat (5) @(posedge clk);
        #1;
        check_eq("bp_accepted", 32'(nacc), 32'(DEPTH));
        check_eq("bp_level", 32'(fifo_level), 32'(DEPTH));
        check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        check_eq("bp_no_writes", 32'(log_q.size() - base), 32'd0);
        trdy = 1'b1;
        wait_done("bp");
        check_eq("bp_log", log_code(base), enc("WWWWWWWWWWWWWWWW"));

        // RRDY pending twice ahead of a queued write.
        trdy = 1'b0;
        push_try(1'b1, 8'hA5, acc);
        repeat (3) @(posedge clk);
        #1;
        base = log_q.size();
        rx_req = rx_req + 2;
        trdy = 1'b1;
        wait_done("rx");
        check_eq("rx_log", log_code(base), enc("RRW"));

        // Simultaneous push and pop at level 5, then pop at full.
        trdy = 1'b0;
        for (int i = 0; i < 5; i++)
            push_try(1'b1, 8'h60 + 8'(i), acc);
        check_eq("pp_level5", 32'(fifo_level), 32'd5);
        trdy = 1'b1;
        push_try(1'b1, 8'h70, acc);
        trdy = 1'b0;
        check_eq("pp_accepted", 32'(acc), 32'd1);
        @(negedge clk);
        check_eq("pp_level_same", 32'(fifo_level), 32'd5);
        @(posedge clk);
        #1;
        for (int i = 0; i < 20 && in_ready; i++)
            push_try(1'b1, 8'h80 + 8'(i), acc);
        check_eq("full_level", 32'(fifo_level), 32'(DEPTH));
        trdy = 1'b1;
        push_try(1'b1, 8'h99, acc);
        check_eq("full_push_refused", 32'(acc), 32'd0);
        @(negedge clk);
        check_eq("full_pop_level", 32'(fifo_level), 32'(DEPTH - 1));
        @(posedge clk);
        #1;
        wait_done("full");

        // Reset in the middle of a write.
        push_try(1'b1, 8'hC3, acc);
        for (int n = 0; n < 50 && !(spi_select && !spi_write_n); n++)
            @(negedge clk);
        check_eq("mid_wr_seen", 32'(spi_select && !spi_write_n), 32'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("mrst_spi", 32'({spi_select, spi_write_n, spi_read_n, spi_addr, spi_wdata}),
                 32'({1'b0, 1'b1, 1'b1, 3'd0, 16'h0000}));
        check_eq("mrst_level", 32'(fifo_level), 32'd0);
        check_eq("mrst_tft_dc", 32'(tft_dc), 32'd0);
        check_eq("mrst_busy", 32'(busy), 32'd0);
        check_eq("mrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        base = log_q.size();
        push_try(1'b0, 8'h5A, acc);
        wait_done("post_rst");
        check_eq("post_rst_log", log_code(base), enc("W"));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
